// File: rtl/branch_target_buffer.sv
// Two-way set-associative branch target buffer with 2-bit saturating direction
// counters. Zero-latency lookup for the fetch PC; trained by execute-stage outcomes.
module branch_target_buffer #(
  parameter int SETS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        hit,
  output logic [31:0] brb,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        flush
);

  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = 30 - IDX;

  typedef logic [IDX-1:0]   idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  logic [SETS-1:0][1:0]        valid_q, valid_d;
  logic [SETS-1:0]             lru_q, lru_d;
  tag_t [SETS-1:0][1:0]        tag_q, tag_d;
  logic [SETS-1:0][1:0][31:0]  target_q, target_d;
  logic [SETS-1:0][1:0][1:0]   ctr_q, ctr_d;

  idx_t       lk_idx;
  tag_t       lk_tag;
  logic [1:0] lk_match;
  logic       lk_way;

  idx_t       up_idx;
  tag_t       up_tag;
  logic [1:0] up_match;
  logic       up_way;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc[1:0], upd_pc[1:0]};

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Lookup: purely combinational from registered state, way 0 wins on a double match
  always_comb begin
    lk_idx      = pc[IDX+1:2];
    lk_tag      = pc[31:IDX+2];
    lk_match[0] = valid_q[lk_idx][0] && (tag_q[lk_idx][0] == lk_tag);
    lk_match[1] = valid_q[lk_idx][1] && (tag_q[lk_idx][1] == lk_tag);
    lk_way      = ~lk_match[0];
    hit         = (lk_match[0] | lk_match[1]) & ctr_q[lk_idx][lk_way][1];
    brb         = hit ? target_q[lk_idx][lk_way] : 32'd0;
  end

  // Update: up_way is the matching way on a hit, otherwise the allocation victim
  always_comb begin
    valid_d  = valid_q;
    lru_d    = lru_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;

    up_idx      = upd_pc[IDX+1:2];
    up_tag      = upd_pc[31:IDX+2];
    up_match[0] = valid_q[up_idx][0] && (tag_q[up_idx][0] == up_tag);
    up_match[1] = valid_q[up_idx][1] && (tag_q[up_idx][1] == up_tag);

    if (up_match[0])               up_way = 1'b0;
    else if (up_match[1])          up_way = 1'b1;
    else if (!valid_q[up_idx][0])  up_way = 1'b0;
    else if (!valid_q[up_idx][1])  up_way = 1'b1;
    else                           up_way = lru_q[up_idx];

    if (flush) begin
      valid_d = '0;
      lru_d   = '0;
    end else if (upd_valid) begin
      if (upd_taken) begin
        valid_d[up_idx][up_way]  = 1'b1;
        tag_d[up_idx][up_way]    = up_tag;
        target_d[up_idx][up_way] = upd_target;
        ctr_d[up_idx][up_way]    = (|up_match) ? sat_inc(ctr_q[up_idx][up_way]) : 2'b10;
        lru_d[up_idx]            = ~up_way;
      end else if (|up_match) begin
        ctr_d[up_idx][up_way]    = sat_dec(ctr_q[up_idx][up_way]);
        lru_d[up_idx]            = ~up_way;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      lru_q   <= '0;
    end else begin
      valid_q <= valid_d;
      lru_q   <= lru_d;
    end
  end

  // Entry payload is only meaningful while valid, so it carries no reset
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
    ctr_q    <= ctr_d;
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios with fixed
// expectations plus randomized traffic against a behavioural table model.
module tb_branch_target_buffer;

  localparam int SETS = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        hit;
  logic [31:0] brb;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        flush;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: per set, two slots holding the architectural entry fields
  bit          m_valid [SETS][2];
  int unsigned m_tag   [SETS][2];
  logic [31:0] m_tgt   [SETS][2];
  int          m_ctr   [SETS][2];
  int          m_lru   [SETS];

  branch_target_buffer #(.SETS(SETS)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .hit        (hit),
    .brb        (brb),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_taken  (upd_taken),
    .flush      (flush)
  );

  always #5 clk = ~clk;

  function automatic int unsigned set_of(input logic [31:0] a);
    return (a / 4) % SETS;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a / (4 * SETS);
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < SETS; s++) begin
      m_valid[s][0] = 1'b0;
      m_valid[s][1] = 1'b0;
      m_lru[s]      = 0;
    end
  endfunction

  function automatic int m_find(input logic [31:0] a);
    int s;
    s = set_of(a);
    for (int w = 0; w < 2; w++)
      if (m_valid[s][w] && m_tag[s][w] == tag_of(a)) return w;
    return -1;
  endfunction

  function automatic void m_lookup(input logic [31:0] a, output bit h, output logic [31:0] t);
    int s, w;
    s = set_of(a);
    w = m_find(a);
    h = (w >= 0) && (m_ctr[s][w] >= 2);
    t = h ? m_tgt[s][w] : 32'd0;
  endfunction

  function automatic void m_update(input logic [31:0] a, input logic [31:0] tgt, input bit tk);
    int s, w;
    s = set_of(a);
    w = m_find(a);
    if (tk) begin
      if (w >= 0) begin
        m_ctr[s][w] = (m_ctr[s][w] < 3) ? m_ctr[s][w] + 1 : 3;
      end else begin
        if (!m_valid[s][0])      w = 0;
        else if (!m_valid[s][1]) w = 1;
        else                     w = m_lru[s];
        m_valid[s][w] = 1'b1;
        m_tag[s][w]   = tag_of(a);
        m_ctr[s][w]   = 2;
      end
      m_tgt[s][w] = tgt;
      m_lru[s]    = 1 - w;
    end else if (w >= 0) begin
      m_ctr[s][w] = (m_ctr[s][w] > 0) ? m_ctr[s][w] - 1 : 0;
      m_lru[s]    = 1 - w;
    end
  endfunction

  task automatic drive(input logic [31:0] p, input logic uv, input logic [31:0] upc,
                       input logic [31:0] utgt, input logic utk, input logic fl, input logic r);
    pc = p; upd_valid = uv; upd_pc = upc; upd_target = utgt; upd_taken = utk;
    flush = fl; rst = r;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst)            m_clear();
    else if (flush)     m_clear();
    else if (upd_valid) m_update(upd_pc, upd_target, upd_taken);
    #1;
  endtask

  task automatic do_reset();
    drive(32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic upd(input logic [31:0] a, input logic [31:0] tgt, input logic tk);
    drive(32'h0, 1'b1, a, tgt, tk, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] p;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      p = (i == 0) ? 32'h100 : $urandom;
      drive(p, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (hit !== 1'b0 || brb !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_lookup pc=%h: got hit=%b brb=%h, want hit=0 brb=0", p, hit, brb);
      end
      tick();
    end
  endtask

  task automatic test_alloc_hit();
    do_reset();
    drive(32'h100, 1'b1, 32'h100, 32'h240, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (hit !== 1'b0 || brb !== 32'd0) begin
      n_fail++;
      $display("FAIL alloc_same_cycle: got hit=%b brb=%h, want hit=0 brb=0", hit, brb);
    end
    tick();
    drive(32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (hit !== 1'b1 || brb !== 32'h240) begin
      n_fail++;
      $display("FAIL alloc_next_cycle: got hit=%b brb=%h, want hit=1 brb=00000240", hit, brb);
    end
    tick();
  endtask

  task automatic test_hysteresis();
    bit tk [6]    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit exp_h [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] exp_b;
    do_reset();
    upd(32'h100, 32'h240, 1'b1);
    for (int i = 0; i < 6; i++) begin
      upd(32'h100, 32'h240, tk[i]);
      drive(32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      exp_b = exp_h[i] ? 32'h240 : 32'd0;
      n_tests++;
      if (hit !== exp_h[i] || brb !== exp_b) begin
        n_fail++;
        $display("FAIL hysteresis step %0d: got hit=%b brb=%h, want hit=%b brb=%h",
                 i, hit, brb, exp_h[i], exp_b);
      end
      tick();
    end
  endtask

  task automatic test_replacement();
    logic [31:0] addr [3]  = '{32'h000, 32'h020, 32'h040};
    logic [31:0] tgt  [3]  = '{32'hA00, 32'hA20, 32'hA40};
    bit          exp_h [3] = '{1'b0, 1'b1, 1'b1};
    logic [31:0] exp_b;
    do_reset();
    for (int i = 0; i < 3; i++) upd(addr[i], tgt[i], 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(addr[i], 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      exp_b = exp_h[i] ? tgt[i] : 32'd0;
      n_tests++;
      if (hit !== exp_h[i] || brb !== exp_b) begin
        n_fail++;
        $display("FAIL replacement pc=%h: got hit=%b brb=%h, want hit=%b brb=%h",
                 addr[i], hit, brb, exp_h[i], exp_b);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    logic [31:0] addr [3] = '{32'h300, 32'h100, 32'h180};
    do_reset();
    upd(32'h100, 32'h240, 1'b1);
    upd(32'h180, 32'h280, 1'b1);
    drive(32'h0, 1'b1, 32'h300, 32'h340, 1'b1, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(addr[i], 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (hit !== 1'b0 || brb !== 32'd0) begin
        n_fail++;
        $display("FAIL flush pc=%h: got hit=%b brb=%h, want hit=0 brb=0", addr[i], hit, brb);
      end
      tick();
    end
  endtask

  task automatic test_alias();
    do_reset();
    upd(32'h100, 32'h240, 1'b1);
    drive(32'h140, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (hit !== 1'b0 || brb !== 32'd0) begin
      n_fail++;
      $display("FAIL alias_tag: got hit=%b brb=%h, want hit=0 brb=0", hit, brb);
    end
    tick();
    drive(32'h102, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (hit !== 1'b1 || brb !== 32'h240) begin
      n_fail++;
      $display("FAIL alias_low_bits: got hit=%b brb=%h, want hit=1 brb=00000240", hit, brb);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    upd(32'h100, 32'h240, 1'b1);
    upd(32'h100, 32'h250, 1'b1);
    upd(32'h100, 32'h260, 1'b0);
    upd(32'h100, 32'h260, 1'b0);
    drive(32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (hit !== 1'b0 || brb !== 32'd0) begin
      n_fail++;
      $display("FAIL back_to_back_ctr1: got hit=%b brb=%h, want hit=0 brb=0", hit, brb);
    end
    tick();
    upd(32'h100, 32'h270, 1'b1);
    drive(32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (hit !== 1'b1 || brb !== 32'h270) begin
      n_fail++;
      $display("FAIL back_to_back_retrain: got hit=%b brb=%h, want hit=1 brb=00000270", hit, brb);
    end
    tick();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) != 0)
      a = 32'(($urandom_range(0, 1) << 31) | ($urandom_range(0, 3) << 5) |
              ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
    return a;
  endfunction

  task automatic test_random();
    bit          eh;
    logic [31:0] eb;
    logic [31:0] p;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      p = rand_addr();
      drive(p, ($urandom_range(0, 3) != 0), rand_addr(), $urandom, ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 49) == 0), ($urandom_range(0, 199) == 0));
      m_lookup(p, eh, eb);
      n_tests++;
      if (hit !== eh || brb !== eb) begin
        n_fail++;
        $display("FAIL random cycle %0d pc=%h: got hit=%b brb=%h, want hit=%b brb=%h",
                 i, p, hit, brb, eh, eb);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0; pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_target = '0;
    upd_taken = 1'b0; flush = 1'b0;
    m_clear();
    test_reset();
    test_alloc_hit();
    test_hysteresis();
    test_replacement();
    test_flush();
    test_alias();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
